// File: rtl/sar_compare_search_pkg.sv
// Shared definitions for the SAR compare-search engine.
//   state_t       : FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   VERDICT_*     : legal {gt,lt,eq} flag patterns from the comparator
//   max_probes()  : probe budget for a given width (mid rounds down, so the
//                   all-ones target needs one probe more than WIDTH)
package sar_compare_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Verdict patterns, ordered {gt, lt, eq}
  localparam logic [2:0] VERDICT_GT = 3'b100;
  localparam logic [2:0] VERDICT_LT = 3'b010;
  localparam logic [2:0] VERDICT_EQ = 3'b001;

  localparam int DEF_WIDTH  = 8;
  localparam int MAX_PROBES = DEF_WIDTH + 1;

  function automatic int max_probes(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sar_compare_search.sv
// Binary-search engine that locates a hidden WIDTH-bit target by driving the
// B operand of an external comparator and consuming its GT/LT/EQ verdicts.
// The comparator may be combinational or pipelined; each probe is held until
// a verdict arrives with cmp_valid.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a search (only honoured in IDLE)
//   probe, probe_valid  : value under test, stable while probe_valid=1
//   cmp_valid, cmp_gt/lt/eq : verdict from the comparator (target vs probe)
//   busy                : not IDLE
//   done                : one-cycle pulse when a search ends
//   found, error, result: outcome of last search, held until next start
module sar_compare_search
  import sar_compare_search_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  localparam int              CW      = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]   CNT_MAX = CW'(max_probes(WIDTH));
  localparam logic [WIDTH-1:0] ONES   = '1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0] probe_n, result_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             found_n, error_n;

  // Midpoint at WIDTH+1 bits so lo+hi cannot wrap; rounds down.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mid;
  assign sum = {1'b0, lo} + {1'b0, hi};
  assign mid = sum[WIDTH:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= ONES;
      cnt    <= '0;
      probe  <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      cnt    <= cnt_n;
      probe  <= probe_n;
      found  <= found_n;
      error  <= error_n;
      result <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    cnt_n    = cnt;
    probe_n  = probe;
    found_n  = found;
    error_n  = error;
    result_n = result;
    case (state)
      IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = ONES;
          cnt_n    = '0;
          found_n  = 1'b0;
          error_n  = 1'b0;
          result_n = '0;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        probe_n = mid;
        cnt_n   = cnt + CW'(1);
        state_n = WAIT;
      end
      WAIT: begin
        if (cmp_valid) begin
          state_n = DONE;
          case ({cmp_gt, cmp_lt, cmp_eq})
            VERDICT_EQ: begin
              found_n  = 1'b1;
              result_n = probe;
            end
            // Running off either end of the range, or out of probes, means
            // the comparator contradicted itself somewhere.
            VERDICT_GT: begin
              if (probe == ONES || cnt == CNT_MAX) begin
                error_n = 1'b1;
              end else begin
                lo_n    = probe + ONE;
                state_n = ISSUE;
              end
            end
            VERDICT_LT: begin
              if (probe == '0 || cnt == CNT_MAX) begin
                error_n = 1'b1;
              end else begin
                hi_n    = probe - ONE;
                state_n = ISSUE;
              end
            end
            default: error_n = 1'b1;
          endcase
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign probe_valid = (state == WAIT);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_sar_compare_search.sv
// Scoreboard bench: the driver pushes expected probe sequences and outcomes
// from a plain-arithmetic search model; a negedge monitor pops and compares
// whenever the DUT presents a new probe or a done pulse.
module tb_sar_compare_search;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         cmp_valid, cmp_gt, cmp_lt, cmp_eq;
  logic         busy, done, found, error;
  logic [W-1:0] result;

  sar_compare_search #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .probe(probe), .probe_valid(probe_valid),
    .cmp_valid(cmp_valid), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .found(found), .error(error), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fnd;
    bit err;
    int res;
    int nprobes;
    int cycles;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_seen = 0;
  int   exp_probe[$];
  exp_t exp_res[$];

  // Responder: 0 = honest comparator, 1 = always gt, 2 = gt&lt illegal
  int   mode_r = 0;
  int   tgt_r = 0;
  int   lat_r = 0;
  int   wcnt = 0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= probe_valid ? wcnt + 1 : 0;
  end

  always_comb begin
    cmp_gt = 1'b0;
    cmp_lt = 1'b0;
    cmp_eq = 1'b0;
    case (mode_r)
      0: begin
        cmp_gt = (tgt_r > int'(probe));
        cmp_lt = (tgt_r < int'(probe));
        cmp_eq = (tgt_r == int'(probe));
      end
      1: cmp_gt = 1'b1;
      default: begin
        cmp_gt = 1'b1;
        cmp_lt = 1'b1;
      end
    endcase
    cmp_valid = probe_valid && (wcnt >= lat_r);
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: bisect the interval [0,255] with integer arithmetic; a search
  // that needs more than 9 probes or leaves the range is an error.
  function automatic void push_expect(input int tgt, input int mode, input int lat);
    int lo = 0, hi = 255, n = 0, m;
    bit fnd = 0, err = 0;
    while (1) begin
      m = (lo + hi) / 2;
      n++;
      exp_probe.push_back(m);
      if (mode == 2) begin err = 1; break; end
      if (mode == 0 && tgt == m) begin fnd = 1; break; end
      if (mode == 1 || tgt > m) begin
        if (m == 255 || n == 9) begin err = 1; break; end
        lo = m + 1;
      end else begin
        if (m == 0 || n == 9) begin err = 1; break; end
        hi = m - 1;
      end
    end
    exp_res.push_back('{fnd, err, fnd ? tgt : 0, n, n * (2 + lat) + 1});
  endfunction

  // Monitor
  bit           pv_prev = 0;
  logic [W-1:0] probe_prev = '0;
  int           pc = 0;

  always @(negedge clk) begin
    if (reset) begin
      pv_prev = 0;
      pc      = 0;
    end else begin
      if (probe_valid && !pv_prev) begin
        pc++;
        if (exp_probe.size() == 0) chk("unexpected_probe", 1, 0);
        else chk("probe_value", int'(probe), exp_probe.pop_front());
      end else if (probe_valid && pv_prev) begin
        chk("probe_hold", int'(probe), int'(probe_prev));
      end
      if (found && error) chk("found_error_exclusive", 1, 0);
      if (done) begin
        if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_res.pop_front();
          chk("found",   int'(found), int'(e.fnd));
          chk("error",   int'(error), int'(e.err));
          chk("result",  int'(result), e.res);
          chk("nprobes", pc, e.nprobes);
          chk("latency", cyc - start_cyc, e.cycles);
        end
        pc = 0;
        done_seen++;
      end
      pv_prev    = probe_valid;
      probe_prev = probe;
    end
  end

  task automatic run_search(input int tgt, input int mode, input int lat);
    int  ds;
    bit  ok = 0;
    mode_r = mode;
    tgt_r  = tgt;
    lat_r  = lat;
    push_expect(tgt, mode, lat);
    ds        = done_seen;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_seen != ds) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("done_timeout", 0, 1);
      exp_probe.delete();
      exp_res.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},        int'(busy), 0);
    chk({tag, "_done"},        int'(done), 0);
    chk({tag, "_probe_valid"}, int'(probe_valid), 0);
    chk({tag, "_probe"},       int'(probe), 0);
    chk({tag, "_found"},       int'(found), 0);
    chk({tag, "_error"},       int'(error), 0);
    chk({tag, "_result"},      int'(result), 0);
  endtask

  initial begin
    bit hit;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_search(127, 0, 0);   // single probe, done 3 cycles after start
    run_search(0,   0, 0);
    run_search(255, 0, 0);
    run_search(0,   1, 0);   // always gt: climbs to 255 then error
    run_search(0,   2, 0);   // illegal gt&lt on first probe
    run_search(77,  0, 3);   // slow comparator

    for (int i = 0; i < 20; i++)
      run_search(int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 3)));

    // Reset while waiting on the third probe (127, 63, 95 for target 100)
    mode_r = 0; tgt_r = 100; lat_r = 2;
    push_expect(100, 0, 2);
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 100; k++) begin
      if (probe_valid && probe == 8'd95) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    chk("reach_third_probe", int'(hit), 1);
    reset = 1'b1;
    exp_probe.delete();
    exp_res.delete();
    @(posedge clk); #1;
    chk_idle_outputs("midreset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_search(200, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("leftover_results", exp_res.size(), 0);
    chk("leftover_probes", exp_probe.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
